// File: rtl/rc4_engine_if.sv
// S-memory bus for rc4_engine: one 256x8 synchronous RAM with 2-edge read latency.
//   s_address : word address (engine -> memory)
//   s_data    : write data   (engine -> memory)
//   s_wren    : write enable (engine -> memory)
//   s_q       : read data    (memory -> engine), valid two edges after address
interface rc4_engine_if;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;

  modport master (output s_address, output s_data, output s_wren, input s_q);
  modport slave  (input s_address, input s_data, input s_wren, output s_q);
endinterface

// File: rtl/rc4_engine.sv
// RC4 keystream engine: builds S in an external RAM (INIT), scrambles it with the
// key (KSA, 8 cycles/byte), then emits MSG_LEN keystream bytes (PRGA, 12 cycles/byte).
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : run request, honoured only while idle
//   secret_key     : key, byte 0 in the MSBs; captured at start
//   mem            : S-memory bus (master side); idle fields read 0 for OR-muxing
//   busy           : high whenever not idle
//   done           : one-cycle pulse at run completion
//   ks_valid       : one-cycle strobe per keystream byte
//   ks_byte        : keystream byte, held until the next strobe
//   ks_index       : 0-based index of ks_byte
module rc4_engine #(
  parameter  int unsigned KEY_BYTES = 3,
  parameter  int unsigned MSG_LEN   = 32,
  localparam int unsigned KW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int unsigned KCW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  rc4_engine_if.master           mem,
  output logic                   busy,
  output logic                   done,
  output logic                   ks_valid,
  output logic [7:0]             ks_byte,
  output logic [KW-1:0]          ks_index
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_RDI, ST_WTI, ST_CAPI, ST_RDJ, ST_WTJ, ST_CAPJ,
    ST_WRI, ST_WRJ, ST_INC, ST_RDK, ST_WTK, ST_OUT, ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   prga_q, prga_d;
  logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KW-1:0]          k_q, k_d;
  logic [KCW-1:0]         kc_q, kc_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             addr_q, addr_d, data_q, data_d;
  logic                   wren_q, wren_d;
  logic                   busy_q, busy_d, done_q, done_d, ksv_q, ksv_d;
  logic [7:0]             ksb_q, ksb_d;
  logic [KW-1:0]          ksi_q, ksi_d;
  logic [7:0]             key_byte;

  // Key byte selected by the wrapping key counter (i mod KEY_BYTES without a divider).
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (kc_q == KCW'(n)) key_byte = key_q[8*(KEY_BYTES-1-n) +: 8];
    end
  end

  // Next state, datapath, and the registered bus/status values for the next cycle.
  always_comb begin
    state_d = state_q;
    prga_d  = prga_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    kc_d    = kc_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    ksb_d   = ksb_q;
    ksi_d   = ksi_q;
    ksv_d   = 1'b0;
    done_d  = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    wren_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          prga_d  = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          kc_d    = '0;
          key_d   = secret_key;
        end
      end
      ST_INIT: begin
        if (i_q == 8'd255) begin
          state_d = ST_RDI;
          i_d     = '0;
          j_d     = '0;
          kc_d    = '0;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      ST_RDI:  state_d = ST_WTI;
      ST_WTI:  state_d = ST_CAPI;
      ST_CAPI: begin
        state_d = ST_RDJ;
        si_d    = mem.s_q;
        j_d     = prga_q ? (j_q + mem.s_q) : (j_q + mem.s_q + key_byte);
      end
      ST_RDJ:  state_d = ST_WTJ;
      ST_WTJ:  state_d = ST_CAPJ;
      ST_CAPJ: begin
        state_d = ST_WRI;
        sj_d    = mem.s_q;
      end
      ST_WRI:  state_d = ST_WRJ;
      ST_WRJ: begin
        if (prga_q) begin
          state_d = ST_RDK;
        end else begin
          kc_d = (kc_q == KCW'(KEY_BYTES - 1)) ? '0 : kc_q + KCW'(1);
          if (i_q == 8'd255) begin
            state_d = ST_INC;
            prga_d  = 1'b1;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
          end else begin
            state_d = ST_RDI;
            i_d     = i_q + 8'd1;
          end
        end
      end
      ST_INC: begin
        state_d = ST_RDI;
        i_d     = i_q + 8'd1;
      end
      ST_RDK:  state_d = ST_WTK;
      ST_WTK:  state_d = ST_OUT;
      ST_OUT: begin
        ksb_d = mem.s_q;
        ksi_d = k_q;
        ksv_d = 1'b1;
        if (k_q == KW'(MSG_LEN - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_INC;
          k_d     = k_q + KW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus fields are driven only in the cycles that use them; all else stays 0.
    case (state_d)
      ST_INIT: begin
        addr_d = i_d;
        data_d = i_d;
        wren_d = 1'b1;
      end
      ST_RDI: addr_d = i_d;
      ST_RDJ: addr_d = j_d;
      ST_WRI: begin
        addr_d = i_d;
        data_d = sj_d;
        wren_d = 1'b1;
      end
      ST_WRJ: begin
        addr_d = j_d;
        data_d = si_d;
        wren_d = 1'b1;
      end
      ST_RDK:  addr_d = si_d + sj_d;
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prga_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      kc_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ksv_q   <= 1'b0;
      ksb_q   <= '0;
      ksi_q   <= '0;
    end else begin
      state_q <= state_d;
      prga_q  <= prga_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kc_q    <= kc_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ksv_q   <= ksv_d;
      ksb_q   <= ksb_d;
      ksi_q   <= ksi_d;
    end
  end

  assign mem.s_address = addr_q;
  assign mem.s_data    = data_q;
  assign mem.s_wren    = wren_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ks_valid      = ksv_q;
  assign ks_byte       = ksb_q;
  assign ks_index      = ksi_q;

endmodule

// File: tb/tb_rc4_engine.sv
// Testbench for rc4_engine: two instances (3-byte key / 10 bytes, 4-byte key / 5 bytes),
// each with a 2-edge-latency S-memory model; keystream checked through a scoreboard.
module tb_rc4_engine;
  localparam int unsigned KA    = 3;
  localparam int unsigned MA    = 10;
  localparam int unsigned KB    = 4;
  localparam int unsigned MB    = 5;
  localparam int          LIMIT = 3000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          start_a, start_b;
  logic [23:0]   key_a;
  logic [31:0]   key_b;
  logic          busy_a, done_a, ksv_a, busy_b, done_b, ksv_b;
  logic [7:0]    ksb_a, ksb_b;
  logic [3:0]    ksi_a;
  logic [2:0]    ksi_b;

  rc4_engine_if bus_a ();
  rc4_engine_if bus_b ();

  rc4_engine #(.KEY_BYTES(KA), .MSG_LEN(MA)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .secret_key(key_a), .mem(bus_a),
    .busy(busy_a), .done(done_a), .ks_valid(ksv_a), .ks_byte(ksb_a), .ks_index(ksi_a)
  );

  rc4_engine #(.KEY_BYTES(KB), .MSG_LEN(MB)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .secret_key(key_b), .mem(bus_b),
    .busy(busy_b), .done(done_b), .ks_valid(ksv_b), .ks_byte(ksb_b), .ks_index(ksi_b)
  );

  // S-memory models: address registered on one edge, data registered on the next.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] ra_a, q_a, ra_b, q_b;
  always @(posedge clock) begin
    if (bus_a.s_wren) mem_a[bus_a.s_address] <= bus_a.s_data;
    ra_a <= bus_a.s_address;
    q_a  <= mem_a[ra_a];
    if (bus_b.s_wren) mem_b[bus_b.s_address] <= bus_b.s_data;
    ra_b <= bus_b.s_address;
    q_b  <= mem_b[ra_b];
  end
  assign bus_a.s_q = q_a;
  assign bus_b.s_q = q_b;

  typedef struct {
    int unsigned which;
    int unsigned idx;
    logic [7:0]  b;
  } vec_t;

  vec_t vecs [15];
  vec_t sb_a [$];
  vec_t sb_b [$];
  vec_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every keystream strobe pops and compares one expected record.
  always @(negedge clock) begin
    if (reset_n && ksv_a) begin
      if (sb_a.size() == 0) check("ks_a_unexpected_strobe", 1, 0);
      else begin
        e_mon = sb_a.pop_front();
        check("ks_a_byte", ksb_a, e_mon.b);
        check("ks_a_index", ksi_a, e_mon.idx);
      end
    end
    if (reset_n && ksv_b) begin
      if (sb_b.size() == 0) check("ks_b_unexpected_strobe", 1, 0);
      else begin
        e_mon = sb_b.pop_front();
        check("ks_b_byte", ksb_b, e_mon.b);
        check("ks_b_index", ksi_b, e_mon.idx);
      end
    end
  end

  task automatic drive_start(input int w, input logic v);
    if (w == 0) start_a = v;
    else        start_b = v;
  endtask

  task automatic drive_key(input int w, input logic [31:0] k);
    if (w == 0) key_a = k[23:0];
    else        key_b = k;
  endtask

  task automatic sample(input int w, output logic wr, output logic [7:0] ad, output logic [7:0] da,
                        output logic bz, output logic dn);
    if (w == 0) begin
      wr = bus_a.s_wren; ad = bus_a.s_address; da = bus_a.s_data; bz = busy_a; dn = done_a;
    end else begin
      wr = bus_b.s_wren; ad = bus_b.s_address; da = bus_b.s_data; bz = busy_b; dn = done_b;
    end
  endtask

  task automatic load_sb(input int w);
    for (int n = 0; n < 15; n++) begin
      if (vecs[n].which == w) begin
        if (w == 0) sb_a.push_back(vecs[n]);
        else        sb_b.push_back(vecs[n]);
      end
    end
  endtask

  // One run: start, optional extra start pulse, optional reset, per-cycle bus-usage audit.
  task automatic run(input int w, input logic [31:0] key, input int mid_start, input int rst_at);
    int         m, lat, bus_err, p, ea, ed, done_cyc;
    bit         ew, ez;
    logic       wr, bz, dn;
    logic [7:0] ad, da;
    m        = (w == 0) ? MA : MB;
    lat      = 256 + 2048 + 12 * m + 1;
    bus_err  = 0;
    done_cyc = -1;
    @(negedge clock);
    drive_key(w, key);
    drive_start(w, 1'b1);
    @(posedge clock);
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clock);
      if (c == 1) begin
        drive_start(w, 1'b0);
        drive_key(w, ~key);
      end
      if (c == mid_start)     drive_start(w, 1'b1);
      if (c == mid_start + 1) drive_start(w, 1'b0);
      if (c == rst_at) begin
        check("bus_usage_before_reset", bus_err, 0);
        reset_n = 1'b0;
        #1;
        sample(w, wr, ad, da, bz, dn);
        check("rst_mid_addr", ad, 0);
        check("rst_mid_data", da, 0);
        check("rst_mid_wren", wr, 0);
        check("rst_mid_busy", bz, 0);
        check("rst_mid_ks_byte", ksb_a, 0);
        check("rst_mid_ks_index", ksi_a, 0);
        bus_err = 0;
        repeat (3) begin
          @(negedge clock);
          sample(w, wr, ad, da, bz, dn);
          if (wr || ad != 0 || da != 0 || bz || dn || ksv_a) bus_err++;
        end
        check("bus_zero_in_reset", bus_err, 0);
        reset_n = 1'b1;
        return;
      end
      sample(w, wr, ad, da, bz, dn);
      ea = -1; ed = -1; ew = 1'b0; ez = 1'b0;
      if (c <= 256) begin
        ew = 1'b1; ea = c - 1; ed = c - 1;
      end else if (c <= 2304) begin
        p  = (c - 257) % 8;
        ew = (p >= 6);
        ez = (p inside {1, 2, 4, 5});
        if (p == 0) ea = (c - 257) / 8;
      end else if (c <= 2304 + 12 * m) begin
        p  = (c - 2305) % 12;
        ew = (p == 7 || p == 8);
        ez = (p inside {0, 2, 3, 5, 6, 10, 11});
        if (p == 1) ea = ((c - 2305) / 12 + 1) % 256;
      end else begin
        ez = 1'b1;
      end
      if (wr != ew)                 bus_err++;
      if (!ew && da != 0)           bus_err++;
      if (ez && ad != 0)            bus_err++;
      if (ea >= 0 && int'(ad) != ea) bus_err++;
      if (ed >= 0 && int'(da) != ed) bus_err++;
      if (!bz)                      bus_err++;
      if (dn) begin
        done_cyc = c;
        break;
      end
    end
    check("done_latency", done_cyc, lat);
    check("bus_usage", bus_err, 0);
    @(negedge clock);
    sample(w, wr, ad, da, bz, dn);
    check("busy_after_done", bz, 0);
    check("done_pulse_width", dn, 0);
    check("scoreboard_drained", (w == 0) ? sb_a.size() : sb_b.size(), 0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 8'hEB}; vecs[1]  = '{0, 1, 8'h9F}; vecs[2]  = '{0, 2, 8'h77};
    vecs[3]  = '{0, 3, 8'h81}; vecs[4]  = '{0, 4, 8'hB7}; vecs[5]  = '{0, 5, 8'h34};
    vecs[6]  = '{0, 6, 8'hCA}; vecs[7]  = '{0, 7, 8'h72}; vecs[8]  = '{0, 8, 8'hA7};
    vecs[9]  = '{0, 9, 8'h19};
    vecs[10] = '{1, 0, 8'h60}; vecs[11] = '{1, 1, 8'h44}; vecs[12] = '{1, 2, 8'hDB};
    vecs[13] = '{1, 3, 8'h6D}; vecs[14] = '{1, 4, 8'h41};

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    key_a   = '0;
    key_b   = '0;
    repeat (3) @(negedge clock);
    check("rst_a_addr", bus_a.s_address, 0);
    check("rst_a_data", bus_a.s_data, 0);
    check("rst_a_wren", bus_a.s_wren, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_ks_valid", ksv_a, 0);
    check("rst_a_ks_byte", ksb_a, 0);
    check("rst_a_ks_index", ksi_a, 0);
    check("rst_b_addr", bus_b.s_address, 0);
    check("rst_b_busy", busy_b, 0);
    reset_n = 1'b1;

    load_sb(0);
    run(0, 32'h004B_6579, -1, -1);
    load_sb(1);
    run(1, 32'h5769_6B69, -1, -1);
    load_sb(0);
    run(0, 32'h004B_6579, 700, -1);
    load_sb(0);
    run(0, 32'h004B_6579, -1, 2346);
    check("bytes_left_after_reset", sb_a.size(), 7);
    sb_a.delete();
    load_sb(0);
    run(0, 32'h004B_6579, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
